// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues instruction-memory requests, and holds the IF/ID
// register. A one-entry skid buffer lets one word be fetched while decode is
// stalled. Decode redirects (JR > J/JAL > JBEQ) squash the word fetched in the
// redirect cycle; there is no delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        JBEQ,
  input  logic        J,
  input  logic        JAL,
  input  logic        JR,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
  output logic        align_err
);

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  buf_state_t  state, state_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        align_q;
  logic        acc;
  logic        redir;
  logic [31:0] jbeq_offset;
  logic [31:0] target;

  assign pc_plus4    = pc + 32'd4;
  assign acc         = imem_req && imem_ready;
  assign redir       = valid_q && !stall && (JR || J || JAL || JBEQ);
  assign jbeq_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Redirect target selection: JR first, then J/JAL, then the branch.
  always_comb begin
    target = pc4_q + jbeq_offset;
    if (JR) begin
      target = {jr_target[31:2], 2'b00};
    end else if (J || JAL) begin
      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end
  end

  // Skid buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Skid buffer next state: fill on a stalled fetch, drain when decode moves.
  always_comb begin
    state_next = state;
    if (redir) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: if (stall && acc) state_next = BUF_FULL;
        BUF_FULL:  if (!stall) state_next = BUF_EMPTY;
        default:   state_next = BUF_EMPTY;
      endcase
    end
  end

  // Fetch requests stop while the buffer holds a word or reset is asserted.
  always_comb begin
    imem_req = rst && (state == BUF_EMPTY);
  end

  // PC advances on an accepted fetch unless a redirect overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC_ALIGNED;
    end else if (redir) begin
      pc <= target;
    end else if (acc) begin
      pc <= pc_plus4;
    end
  end

  // Skid buffer capture of the word fetched while decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_instr <= 32'd0;
      buf_pc4   <= 32'd0;
    end else if (state == BUF_EMPTY && stall && acc) begin
      buf_instr <= imem_rdata;
      buf_pc4   <= pc_plus4;
    end
  end

  // IF/ID register: bubble on redirect, otherwise take buffer or fresh word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (redir) begin
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (state == BUF_FULL) begin
        instr_q <= buf_instr;
        pc4_q   <= buf_pc4;
        valid_q <= 1'b1;
      end else if (acc) begin
        instr_q <= imem_rdata;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
      end else begin
        instr_q <= 32'd0;
        pc4_q   <= 32'd0;
        valid_q <= 1'b0;
      end
    end
  end

  // Sticky flag for a JR that targeted a non-word-aligned address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_q <= 1'b0;
    end else if (redir && JR && (jr_target[1:0] != 2'b00)) begin
      align_q <= 1'b1;
    end
  end

  assign imem_addr  = pc;
  assign instr_D    = instr_q;
  assign pc_plus4_D = pc4_q;
  assign valid_D    = valid_q;
  assign align_err  = align_q;

endmodule
